// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The state enum is also exported through the loader's debug port.
package boot_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      CSUM,
      RUN,
      ERROR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_W        = 16;

endpackage

// File: rtl/byte_to_word.sv
// Little-endian 4-byte assembler: the first byte accepted lands in bits [7:0].
// word_valid pulses combinationally alongside the 4th byte, and word carries the full word in that cycle.
module byte_to_word
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  idx;
   logic [23:0] shift;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx   <= '0;
         shift <= '0;
      end else if (clear) begin
         idx   <= '0;
         shift <= '0;
      end else if (byte_en) begin
         idx   <= idx + 2'd1;
         shift <= {byte_in, shift[23:8]};
      end
   end

   assign word       = {byte_in, shift};
   assign word_valid = byte_en && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a counted, XOR-checksummed byte image, writes it into instruction memory,
// and holds the CPU in reset until the image is loaded and its checksum verifies.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [2:0]        dbg_state
);

   localparam logic [COUNT_W:0] CAP = (COUNT_W + 1)'(2 ** ADDR_W);

   state_t             state;
   logic               live;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] widx;
   logic [7:0]         acc;
   logic               accept;
   logic               reload_go;
   logic [COUNT_W-1:0] full_count;
   logic [31:0]        word;
   logic               word_valid;

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready; the source may hold
   // in_valid low for any number of cycles. in_ready is low in reset and for the first cycle after release.
   assign in_ready   = live && (state inside {HDR_LO, HDR_HI, DATA, CSUM});
   assign accept     = in_valid && in_ready;
   assign reload_go  = reload && (state inside {RUN, ERROR});
   assign full_count = {in_data, count[7:0]};
   assign dbg_state  = state;

   byte_to_word u_b2w (
      .clk       (clk),
      .reset     (reset),
      .clear     (reload_go),
      .byte_en   (accept && (state == DATA)),
      .byte_in   (in_data),
      .word      (word),
      .word_valid(word_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HDR_LO;
         live       <= 1'b0;
         count      <= '0;
         widx       <= '0;
         acc        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         live    <= 1'b1;
         imem_we <= 1'b0;
         if (accept && (state != CSUM))
            acc <= acc ^ in_data;
         case (state)
            HDR_LO: if (accept) begin
               count[7:0] <= in_data;
               state      <= HDR_HI;
            end
            HDR_HI: if (accept) begin
               count[15:8] <= in_data;
               // The capacity test is made before any write, so an oversized image leaves memory untouched.
               if ({1'b0, full_count} > CAP) begin
                  state    <= ERROR;
                  load_err <= 1'b1;
               end else if (full_count == '0) begin
                  state <= CSUM;
               end else begin
                  state <= DATA;
               end
            end
            DATA: if (word_valid) begin
               imem_we    <= 1'b1;
               imem_addr  <= widx[ADDR_W-1:0];
               imem_wdata <= DATA_W'(word);
               widx       <= widx + 1'b1;
               if (widx + 1'b1 == count)
                  state <= CSUM;
            end
            CSUM: if (accept) begin
               if (in_data == acc) begin
                  state     <= RUN;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  state    <= ERROR;
                  load_err <= 1'b1;
               end
            end
            RUN, ERROR: if (reload_go) begin
               state     <= HDR_LO;
               count     <= '0;
               widx      <= '0;
               acc       <= '0;
               cpu_reset <= 1'b1;
               load_done <= 1'b0;
               load_err  <= 1'b0;
            end
            default: state <= HDR_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: images are built from a word list, expected writes
// and outcomes come from the image rules (count limit, XOR checksum), not from the loader's state machine.
module tb_imem_boot_loader;

   localparam int ADDR_W = 2;
   localparam int EW     = ADDR_W + 32;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              reload = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              load_done;
   logic              load_err;
   logic [2:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [31:0]   words[$];

   imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset (cpu_reset),
      .load_done (load_done),
      .load_err  (load_err),
      .dbg_state (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the next expected (addr, data) pair.
   always @(negedge clk) begin
      if (reset && imem_we) begin
         if (exp_q.size() == 0) begin
            check("spurious_we", 64'(imem_addr), 64'hdead);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(imem_addr), 64'(e[EW-1:32]));
            check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
         end
      end
   end

   // Driver tasks
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      reload = 1'b0;
      #1;
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_we", 64'(imem_we), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);
      check("rst_wdata", 64'(imem_wdata), 64'd0);
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst_done", 64'(load_done), 64'd0);
      check("rst_err", 64'(load_err), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("rel_ready_high", 64'(in_ready), 64'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall, input bit word_end);
      int t;
      if (stall) repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      reload   = stall && ($urandom_range(0, 3) == 0);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("ready_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         reload   = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reload   = 1'b0;
      if (word_end) begin
         @(negedge clk);
         check("we_latency", 64'(imem_we), 64'd1);
      end
   endtask

   task automatic load_image(input int n, input bit bad, input bit stall);
      logic [7:0]  acc;
      logic [7:0]  b;
      logic [15:0] n16;
      logic [31:0] w;
      n16 = 16'(n);
      acc = n16[7:0] ^ n16[15:8];
      send_byte(n16[7:0], 1'b0, 1'b0);
      send_byte(n16[15:8], 1'b0, 1'b0);
      if (n > CAP) begin
         @(negedge clk);
         check("ovf_err", 64'(load_err), 64'd1);
         check("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
         check("ovf_ready", 64'(in_ready), 64'd0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = words[i];
         exp_q.push_back({ADDR_W'(i), w});
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            acc ^= b;
            send_byte(b, stall, k == 3);
         end
      end
      check("pre_csum_cpu_reset", 64'(cpu_reset), 64'd1);
      send_byte(bad ? ~acc : acc, 1'b0, 1'b0);
      @(negedge clk);
      check("end_cpu_reset", 64'(cpu_reset), 64'(bad));
      check("end_done", 64'(load_done), 64'(!bad));
      check("end_err", 64'(load_err), 64'(bad));
      check("end_ready", 64'(in_ready), 64'd0);
      check("writes_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      @(negedge clk);
      check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
      check("reload_done", 64'(load_done), 64'd0);
      check("reload_err", 64'(load_err), 64'd0);
      check("reload_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic random_words();
      words.delete();
      for (int i = 0; i < CAP; i++) words.push_back($urandom);
   endtask

   // Stimulus
   initial begin
      do_reset();
      repeat (10) begin
         @(negedge clk);
         check("hold_cpu_reset", 64'(cpu_reset), 64'd1);
         check("hold_ready", 64'(in_ready), 64'd1);
      end

      words = '{32'h00100013, 32'h00200093};
      load_image(2, 1'b0, 1'b0);
      do_reload();
      load_image(2, 1'b1, 1'b0);
      do_reload();
      load_image(2, 1'b0, 1'b0);

      do_reload();
      load_image(0, 1'b0, 1'b0);
      do_reload();
      load_image(5, 1'b0, 1'b0);
      do_reload();
      load_image(300, 1'b0, 1'b0);

      random_words();
      do_reload();
      load_image(4, 1'b0, 1'b0);
      do_reload();
      load_image(4, 1'b0, 1'b1);

      // Reset in the middle of a load, just after the first word is written
      do_reload();
      words = '{32'h00100013, 32'h00200093};
      exp_q.push_back({ADDR_W'(0), 32'h00100013});
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h13, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b1);
      do_reset();
      load_image(2, 1'b0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         random_words();
         do_reload();
         load_image($urandom_range(0, CAP + 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
